// File: rtl/sprite_pkg.sv
`default_nettype none
// ============================================================================
// Module      : sprite_pkg
// Description : Shared definitions for sprite renderers: the FSM state
//               encoding and a helper that derives the drawn pixel count.
//               Kept separate so later multi-sprite blocks reuse one encoding.
// Revision    : 1.0 - initial release
// ============================================================================
package sprite_pkg;

    localparam int SPRITE_STATE_W = 3;

    typedef enum logic [SPRITE_STATE_W-1:0] {
        IDLE        = 3'd0,
        WAIT_LOAD   = 3'd1,
        FETCH_SETUP = 3'd2,
        FETCH_LATCH = 3'd3,
        WAIT_HSTART = 3'd4,
        DRAW        = 3'd5
    } sprite_state_t;

    // Pixels drawn per scanline: the ROM row alone, or the row followed by
    // its mirror image.
    function automatic int sprite_pw(input int w, input int mirror);
        return (mirror != 0) ? 2 * w : w;
    endfunction

endpackage : sprite_pkg
`default_nettype wire

// File: rtl/sprite_pixel_sel.sv
`default_nettype none
// ============================================================================
// Module      : sprite_pixel_sel
// Description : Combinational pixel selector. Maps the horizontal pixel
//               counter to a bit of the latched ROM row, applying the
//               horizontal flip and, when MIRROR is set, the mirrored half.
// Ports       : i_row     - latched ROM row (bit 0 is pixel 0)
//               i_xcount  - pixel counter within the scanline
//               i_hflip_l - latched horizontal flip
//               o_pix     - selected pixel value
// Revision    : 1.0 - initial release
// ============================================================================
module sprite_pixel_sel
    import sprite_pkg::*;
#(
    parameter int W      = 8,
    parameter int MIRROR = 1
) (
    input  logic [W-1:0]                            i_row,
    input  logic [$clog2(sprite_pw(W, MIRROR))-1:0] i_xcount,
    input  logic                                    i_hflip_l,
    output logic                                    o_pix
);
    localparam int PW = sprite_pw(W, MIRROR);
    localparam int XW = $clog2(PW);
    localparam logic [XW-1:0] c_PW_LAST = XW'(PW - 1);

    logic [XW-1:0] w_q;

    // The index loop avoids a variable part-select whose index would be
    // wider than the row; q is always below PW, so exactly one arm matches.
    always_comb begin
        w_q   = i_hflip_l ? (c_PW_LAST - i_xcount) : i_xcount;
        o_pix = 1'b0;
        for (int i = 0; i < W; i++) begin
            if (w_q == XW'(i)) begin
                o_pix = i_row[i];
            end
            if ((MIRROR != 0) && (w_q == XW'(2 * W - 1 - i))) begin
                o_pix = i_row[i];
            end
        end
    end

endmodule : sprite_pixel_sel
`default_nettype wire

// File: rtl/sprite_renderer_param.sv
`default_nettype none
// ============================================================================
// Module      : sprite_renderer_param
// Description : Single-sprite scanline renderer. Armed by vstart, it fetches
//               one ROM row per load, waits for hstart and shifts the row
//               out as pixels (optionally mirrored, flipped and stretched).
// Ports       : clk, reset     - clock, synchronous active-high reset
//               vstart         - arm sprite at the top border
//               load           - row fetch permitted
//               hstart         - begin drawing the fetched row
//               hflip, vflip   - flips, captured when vstart is accepted
//               rom_addr       - ROM row address (registered)
//               rom_bits       - ROM row data, valid one clock after rom_addr
//               gfx            - registered pixel output
//               in_progress    - FSM is not idle
//               done           - one-clock pulse after the final pixel
// Revision    : 1.0 - initial release
// ============================================================================
module sprite_renderer_param
    import sprite_pkg::*;
#(
    parameter int W      = 8,
    parameter int H      = 16,
    parameter int MIRROR = 1,
    parameter int XSCALE = 1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 vstart,
    input  logic                 load,
    input  logic                 hstart,
    input  logic                 hflip,
    input  logic                 vflip,
    output logic [$clog2(H)-1:0] rom_addr,
    input  logic [W-1:0]         rom_bits,
    output logic                 gfx,
    output logic                 in_progress,
    output logic                 done
);
    localparam int AW = $clog2(H);
    localparam int PW = sprite_pw(W, MIRROR);
    localparam int XW = $clog2(PW);
    localparam int SW = $clog2(XSCALE) + 1;

    localparam logic [AW-1:0] c_H_LAST  = AW'(H - 1);
    localparam logic [XW-1:0] c_PW_LAST = XW'(PW - 1);
    localparam logic [SW-1:0] c_XS_LAST = SW'(XSCALE - 1);

    sprite_state_t r_state, w_state;
    logic          r_gfx, w_gfx;
    logic          r_done, w_done;
    logic [AW-1:0] r_rom_addr, w_rom_addr;
    logic [AW-1:0] r_ycount, w_ycount;
    logic [XW-1:0] r_xcount, w_xcount;
    logic [SW-1:0] r_subcount, w_subcount;
    logic          r_hflip_l, w_hflip_l;
    logic          r_vflip_l, w_vflip_l;
    logic [W-1:0]  r_row, w_row;
    logic          w_pix;

    sprite_pixel_sel #(
        .W      (W),
        .MIRROR (MIRROR)
    ) u_pixel_sel (
        .i_row     (r_row),
        .i_xcount  (r_xcount),
        .i_hflip_l (r_hflip_l),
        .o_pix     (w_pix)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= IDLE;
            r_gfx      <= 1'b0;
            r_done     <= 1'b0;
            r_rom_addr <= '0;
            r_ycount   <= '0;
            r_xcount   <= '0;
            r_subcount <= '0;
            r_hflip_l  <= 1'b0;
            r_vflip_l  <= 1'b0;
            r_row      <= '0;
        end else begin
            r_state    <= w_state;
            r_gfx      <= w_gfx;
            r_done     <= w_done;
            r_rom_addr <= w_rom_addr;
            r_ycount   <= w_ycount;
            r_xcount   <= w_xcount;
            r_subcount <= w_subcount;
            r_hflip_l  <= w_hflip_l;
            r_vflip_l  <= w_vflip_l;
            r_row      <= w_row;
        end
    end

    // gfx and done default low so every state other than DRAW blanks the
    // pixel on its first clock, and done is a single-clock pulse.
    always_comb begin
        w_state    = r_state;
        w_gfx      = 1'b0;
        w_done     = 1'b0;
        w_rom_addr = r_rom_addr;
        w_ycount   = r_ycount;
        w_xcount   = r_xcount;
        w_subcount = r_subcount;
        w_hflip_l  = r_hflip_l;
        w_vflip_l  = r_vflip_l;
        w_row      = r_row;

        case (r_state)
            IDLE: begin
                w_ycount = '0;
                if (vstart) begin
                    w_hflip_l = hflip;
                    w_vflip_l = vflip;
                    w_state   = WAIT_LOAD;
                end
            end
            WAIT_LOAD: begin
                w_xcount   = '0;
                w_subcount = '0;
                if (load) begin
                    w_state = FETCH_SETUP;
                end
            end
            FETCH_SETUP: begin
                w_rom_addr = r_vflip_l ? (c_H_LAST - r_ycount) : r_ycount;
                w_state    = FETCH_LATCH;
            end
            FETCH_LATCH: begin
                w_row   = rom_bits;
                w_state = WAIT_HSTART;
            end
            WAIT_HSTART: begin
                if (hstart) begin
                    w_state = DRAW;
                end
            end
            DRAW: begin
                w_gfx = w_pix;
                if (r_subcount == c_XS_LAST) begin
                    w_subcount = '0;
                    if (r_xcount == c_PW_LAST) begin
                        // End of scanline; counters are cleared rather
                        // than allowed to roll over.
                        w_xcount = '0;
                        if (r_ycount == c_H_LAST) begin
                            w_ycount = '0;
                            w_done   = 1'b1;
                            w_state  = IDLE;
                        end else begin
                            w_ycount = r_ycount + AW'(1);
                            w_state  = WAIT_LOAD;
                        end
                    end else begin
                        w_xcount = r_xcount + XW'(1);
                    end
                end else begin
                    w_subcount = r_subcount + SW'(1);
                end
            end
            default: begin
                w_state = IDLE;
            end
        endcase
    end

    assign rom_addr    = r_rom_addr;
    assign gfx         = r_gfx;
    assign done        = r_done;
    assign in_progress = (r_state != IDLE);

endmodule : sprite_renderer_param
`default_nettype wire

// File: tb/tb_sprite_renderer_param.sv
`default_nettype none
// ============================================================================
// Module      : tb_sprite_renderer_param
// Description : Self-checking bench for sprite_renderer_param. Three
//               instances cover the default mirrored sprite, an unmirrored
//               hflip sprite and an unmirrored XSCALE=3 sprite. The driver
//               pushes time-stamped expectations into a scoreboard queue; a
//               monitor pops and compares them on the falling edge.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_sprite_renderer_param;

    localparam int K_GFX  = 0;
    localparam int K_IP   = 1;
    localparam int K_DONE = 2;
    localparam int K_ADDR = 3;

    typedef struct {
        int    cyc;
        int    d;
        int    k;
        int    ex;
        string nm;
    } sb_t;

    logic       clk = 1'b0;
    logic       rst;
    logic [2:0] vs, ld, hs, hf, vf;
    logic [2:0] gfx_w, ip_w, dn_w;
    logic [3:0] addr_a;
    logic       addr_b, addr_c;
    logic [7:0] rom_a, rom_b, rom_c;
    int         cyc      = 0;
    int         n_checks = 0;
    int         n_fail   = 0;
    sb_t        sb[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // ROM images: row r of the default sprite is 8'h01 << (r % 8).
    assign rom_a = 8'h01 << addr_a[2:0];
    assign rom_b = 8'b0000_0011;
    assign rom_c = 8'h81;

    sprite_renderer_param #(.W(8), .H(16), .MIRROR(1), .XSCALE(1)) u_dut_a (
        .clk(clk), .reset(rst), .vstart(vs[0]), .load(ld[0]), .hstart(hs[0]),
        .hflip(hf[0]), .vflip(vf[0]), .rom_addr(addr_a), .rom_bits(rom_a),
        .gfx(gfx_w[0]), .in_progress(ip_w[0]), .done(dn_w[0])
    );

    sprite_renderer_param #(.W(8), .H(2), .MIRROR(0), .XSCALE(1)) u_dut_b (
        .clk(clk), .reset(rst), .vstart(vs[1]), .load(ld[1]), .hstart(hs[1]),
        .hflip(hf[1]), .vflip(vf[1]), .rom_addr(addr_b), .rom_bits(rom_b),
        .gfx(gfx_w[1]), .in_progress(ip_w[1]), .done(dn_w[1])
    );

    sprite_renderer_param #(.W(8), .H(2), .MIRROR(0), .XSCALE(3)) u_dut_c (
        .clk(clk), .reset(rst), .vstart(vs[2]), .load(ld[2]), .hstart(hs[2]),
        .hflip(hf[2]), .vflip(vf[2]), .rom_addr(addr_c), .rom_bits(rom_c),
        .gfx(gfx_w[2]), .in_progress(ip_w[2]), .done(dn_w[2])
    );

    function automatic int get_sig(input int d, input int k);
        int v;
        case (k)
            K_GFX:   v = int'(gfx_w[d]);
            K_IP:    v = int'(ip_w[d]);
            K_DONE:  v = int'(dn_w[d]);
            default: v = (d == 0) ? int'(addr_a) : (d == 1) ? int'(addr_b) : int'(addr_c);
        endcase
        return v;
    endfunction

    // Monitor: every entry whose time stamp has arrived is compared now.
    always @(negedge clk) begin : p_monitor
        sb_t e;
        int  act;
        while (sb.size() > 0 && sb[0].cyc <= cyc) begin
            e   = sb.pop_front();
            act = get_sig(e.d, e.k);
            n_checks++;
            if (e.cyc != cyc || act != e.ex) begin
                n_fail++;
                $display("FAIL %s dut%0d cyc %0d (now %0d): got %0d, want %0d",
                         e.nm, e.d, e.cyc, cyc, act, e.ex);
            end
        end
    end

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic push(input int c, input int d, input int k, input int ex, input string nm);
        sb_t e;
        e.cyc = c;
        e.d   = d;
        e.k   = k;
        e.ex  = ex;
        e.nm  = nm;
        sb.push_back(e);
    endtask

    // One scanline. Called on a falling edge with the DUT in WAIT_LOAD.
    // Timing: load at L -> FETCH_SETUP, rom_addr visible at L+2, hstart at
    // hst -> DRAW, pixel t visible at hst+2+t, blank again at hst+2+PW*XS.
    task automatic do_row(input int d, input logic [15:0] pat, input int pw, input int xs,
                          input int a_exp, input bit last, input bit glitch, input int abort_at);
        int L, hst, fin, xab;
        L   = cyc;
        hst = L + (glitch ? 5 : 3);
        fin = hst + 2 + pw * xs;
        xab = hst + 2 + abort_at;
        push(L + 2, d, K_ADDR, a_exp, "rom_addr");
        push(hst, d, K_GFX, 0, "gfx_wait_hstart");
        push(hst, d, K_IP, 1, "in_progress_row");
        for (int t = 0; t < pw * xs; t++) begin
            if (abort_at < 0 || t <= abort_at) begin
                push(hst + 2 + t, d, K_GFX, int'(pat[t / xs]), "gfx_pixel");
            end
        end
        if (abort_at >= 0) begin
            push(xab + 1, d, K_GFX, 0, "gfx_after_reset");
            push(xab + 1, d, K_IP, 0, "in_progress_after_reset");
            push(xab + 1, d, K_DONE, 0, "done_after_reset");
            push(xab + 1, d, K_ADDR, 0, "rom_addr_after_reset");
        end else begin
            push(fin - 1, d, K_DONE, last ? 1 : 0, "done_end_row");
            push(fin - 1, d, K_IP, last ? 0 : 1, "in_progress_end_row");
            push(fin, d, K_GFX, 0, "gfx_after_draw");
            push(fin, d, K_DONE, 0, "done_one_clock");
        end

        ld[d] = 1'b1;
        hs[d] = glitch;            // hstart together with load: load wins
        tick();
        ld[d] = 1'b0;
        hs[d] = 1'b0;
        tick();
        hs[d] = glitch;            // hstart while in FETCH_LATCH: ignored
        tick();
        hs[d] = 1'b0;
        while (cyc < hst) tick();
        hs[d] = 1'b1;
        tick();
        hs[d] = 1'b0;
        if (glitch) begin
            tick();
            tick();
            vs[d] = 1'b1;          // vstart and load during DRAW: ignored
            ld[d] = 1'b1;
            tick();
            vs[d] = 1'b0;
            ld[d] = 1'b0;
        end
        if (abort_at >= 0) begin
            while (cyc < xab) tick();
            rst = 1'b1;
            tick();
            rst = 1'b0;
            while (cyc < xab + 2) tick();
        end else begin
            while (cyc < fin) tick();
        end
    endtask

    task automatic do_frame(input int d, input bit vflp, input bit hflp, input int nrows,
                            input int xs, input int glitch_row, input int abort_row,
                            input int abort_at);
        int          pw, a;
        logic [15:0] pat;
        pw    = (d == 0) ? 16 : 8;
        vs[d] = 1'b1;
        hf[d] = hflp;
        vf[d] = vflp;
        tick();
        vs[d] = 1'b0;
        hf[d] = ~hflp;             // flips must have been captured already
        vf[d] = ~vflp;
        tick();
        for (int r = 0; r < nrows; r++) begin
            a = vflp ? nrows - 1 - r : r;
            if (d == 0) begin
                // Row 8'h01<<k mirrored: pixels k and 15-k are lit.
                pat = (16'h0001 << (a % 8)) | (16'h8000 >> (a % 8));
            end else if (d == 1) begin
                pat = 16'h00C0;    // 8'b00000011 with hflip: pixels 6,7 lit
            end else begin
                pat = 16'h0081;    // 8'h81: pixels 0 and 7 lit
            end
            do_row(d, pat, pw, xs, a, r == nrows - 1, r == glitch_row,
                   (r == abort_row) ? abort_at : -1);
            if (r == abort_row) break;
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: time limit reached, got no finish, want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        vs  = '0;
        ld  = '0;
        hs  = '0;
        hf  = '0;
        vf  = '0;
        repeat (3) tick();
        for (int d = 0; d < 3; d++) begin
            push(cyc + 1, d, K_GFX, 0, "reset_gfx");
            push(cyc + 1, d, K_IP, 0, "reset_in_progress");
            push(cyc + 1, d, K_DONE, 0, "reset_done");
            push(cyc + 1, d, K_ADDR, 0, "reset_rom_addr");
        end
        rst = 1'b0;
        tick();
        tick();

        do_frame(0, 1'b0, 1'b0, 16, 1, 3, -1, 0);   // plain frame, glitches on row 3
        tick();
        do_frame(0, 1'b1, 1'b1, 16, 1, -1, -1, 0);  // vflip: rom_addr 15..0
        tick();
        do_frame(0, 1'b1, 1'b0, 16, 1, -1, 5, 6);   // reset during row 5 draw
        tick();
        do_frame(0, 1'b0, 1'b0, 16, 1, -1, -1, 0);  // restart from rom_addr 0
        tick();
        do_frame(1, 1'b0, 1'b1, 2, 1, -1, -1, 0);   // hflip, no mirror
        tick();
        do_frame(2, 1'b0, 1'b0, 2, 3, -1, -1, 0);   // XSCALE=3, no mirror
        repeat (4) tick();

        if (sb.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard_drain: got %0d pending, want 0", sb.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule : tb_sprite_renderer_param
`default_nettype wire
